// File: rtl/shift_add_mul_ctrl.sv
// Shift-and-add multiply sequencer: runs an external WIDTH-bit adder for
// WIDTH cycles to form an exact 2*WIDTH-bit unsigned product.
module shift_add_mul_ctrl #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH:0]       add_sum,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry out lands in the ACC MSB; the sum LSB shifts into Q.
        acc_d   = add_sum[WIDTH:1];
        q_d     = {add_sum[0], q_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = {add_sum[WIDTH:1], add_sum[0], q_q[WIDTH-1:1]};
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Adder operands are only non-zero while iterating
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == ST_RUN) begin
      add_a = acc_q;
      add_b = q_q[0] ? m_q : '0;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for shift_add_mul_ctrl: stimulus predicts each accepted
// operation's product and done cycle, a monitor checks what the DUT presents.
module tb_shift_add_mul_ctrl;

  localparam int W = 5;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W:0]     add_sum;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Shared ALU adder
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   next_free = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start at edge e completes with done sampled after
  // edge e+W; the unit is free to accept again from edge e+W+2.
  task automatic issue(input bit st, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   edge_n;
    start  = st;
    a      = av;
    b      = bv;
    edge_n = cyc + 1;
    if (st && rst_n && edge_n >= next_free) begin
      e.p   = (2*W)'(av) * (2*W)'(bv);
      e.cyc = edge_n + W;
      sb.push_back(e);
      next_free = edge_n + W + 2;
    end
  endtask

  task automatic drive(input bit st, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    issue(st, av, bv);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom_range(0, 31), $urandom_range(0, 31));
  endtask

  // Asynchronous reset between edges; optionally release with start high
  task automatic async_reset(input bit rel_start, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_product", 32'(product), 0);
    check("rst_add_a", 32'(add_a), 0);
    check("rst_add_b", 32'(add_b), 0);
    sb.delete();
    next_free = 0;
    start = rel_start;
    a = av;
    b = bv;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(rel_start, av, bv);
  endtask

  // Monitor: scoreboard compare on done, plus protocol checks every cycle
  logic [2*W-1:0] last_product = '0;
  int             busy_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_product = '0;
      busy_run     = 0;
    end else begin
      if (!busy) begin
        check("idle_add_a", 32'(add_a), 0);
        check("idle_add_b", 32'(add_b), 0);
      end
      if (done) begin
        check("busy_len", 32'(busy_run), 32'(W));
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", 32'(product), 32'(e.p));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
        last_product = product;
      end else begin
        check("product_held", 32'(product), 32'(last_product));
      end
      if (busy) busy_run++;
      else      busy_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W:0] max_sum;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_product", 32'(product), 0);
    rst_n = 1'b1;
    idle(2);

    drive(1'b1, 5'd5, 5'd3);
    idle(8);

    // Full-scale operands: carry out of the adder must reach ACC
    drive(1'b1, 5'd31, 5'd31);
    drive(1'b0, 5'd31, 5'd31);
    check("first_sum", 32'(add_sum), 31);
    max_sum = '0;
    for (int i = 0; i < W - 1; i++) begin
      drive(1'b0, 5'd31, 5'd31);
      if (busy && add_sum > max_sum) max_sum = add_sum;
    end
    check("carry_seen", 32'(max_sum > 6'd31), 1);
    idle(4);

    drive(1'b1, 5'd0, 5'd17);
    idle(8);
    drive(1'b1, 5'd17, 5'd0);
    idle(8);

    // Second start during RUN is ignored
    drive(1'b1, 5'd7, 5'd9);
    drive(1'b0, 5'd7, 5'd9);
    drive(1'b1, 5'd1, 5'd1);
    idle(8);

    // Reset on RUN cycle 3, then release with start already high
    drive(1'b1, 5'd6, 5'd6);
    drive(1'b0, 5'd6, 5'd6);
    drive(1'b0, 5'd6, 5'd6);
    async_reset(1'b1, 5'd2, 5'd11);
    idle(9);

    repeat (20) drive(1'b1, 5'd3, 5'd4);
    idle(9);

    // Random traffic: sparse starts, operands change every cycle
    repeat (400) drive($urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom_range(0, 31));
    idle(10);

    check("drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mul_ctrl.md
Name: shift_add_mul_ctrl

Overview:
- Sequencer that computes an unsigned WIDTH x WIDTH multiply by iterating a shared combinational adder (WIDTH-bit operands, (WIDTH+1)-bit sum) over WIDTH cycles, using shift-and-add.
- Sits beside the ALU adder and drives that adder's operand inputs. Owns the accumulator, multiplier shift register and iteration counter.
- Start/done handshake to the surrounding ALU control.

Parameters:
- WIDTH, 5, operand width; must equal the adder operand width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, captured when start is accepted.
- b  input  WIDTH  multiplier, captured when start is accepted.
- add_a  output  WIDTH  adder operand A (combinational from state).
- add_b  output  WIDTH  adder operand B (combinational from state).
- add_sum  input  WIDTH+1  adder result, add_a + add_b, same cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  registered result; held until next completion.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE; M, ACC, Q, count, product = 0; busy=0; done=0.
- Internal registers:
  - M[WIDTH-1:0]: multiplicand.
  - ACC[WIDTH-1:0]: accumulator.
  - Q[WIDTH-1:0]: multiplier/low product.
  - count[ceil(log2(WIDTH+1))-1:0]: iteration counter.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge: M<=a, Q<=b, ACC<=0, count<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per edge:
  - ACC <= add_sum[WIDTH:1].
  - Q <= {add_sum[0], Q[WIDTH-1:1]}.
  - count <= count+1.
  - When count==WIDTH-1 at the edge:
    - product <= {add_sum[WIDTH:1], add_sum[0], Q[WIDTH-1:1]}, i.e. the post-shift {ACC,Q}.
    - Go to DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Adder drive (combinational):
  - In RUN: add_a=ACC; add_b = Q[0] ? M : 0.
  - In IDLE and DONE: add_a=0, add_b=0.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - product is stable in DONE and afterwards, until the last RUN edge of the next operation.
- Width rules:
  - The carry out of add_sum is never lost; it shifts into ACC MSB.
  - The full 2*WIDTH product is exact; no overflow is possible.
- Latency:
  - start accepted at edge k → done=1 during the cycle after edge k+WIDTH.
  - Next start can be accepted at edge k+WIDTH+2 at the earliest.
- Boundary conditions:
  - start while RUN or DONE: ignored, not queued.
  - start held high continuously: a new operation begins on each IDLE edge, giving back-to-back operations with one IDLE-or-DONE gap.
  - a or b changing during RUN: no effect; operands were captured at accept.
  - a=0 or b=0: still runs WIDTH cycles; product=0.
  - rst_n asserted mid-RUN or in DONE:
    - Immediate return to IDLE; all registers cleared; no done pulse.
    - After release, the first start begins a fresh operation.
  - rst_n released with start=1: start is sampled on the first edge after release.

Test Plan:
- Reset, then a=5, b=3, start pulse for 1 cycle:
  - busy high for exactly 5 cycles, then done pulses 1 cycle with product=15.
  - add_a/add_b are 0 outside RUN.
- a=31, b=31: product=961 (10'b1111000001). Check add_sum carry reaches ACC: the first iteration gives add_sum=31, and a later iteration gives add_sum>31.
- a=0, b=17, then a=17, b=0:
  - Both yield product=0 after 5 RUN cycles.
  - The prior product stays held until the final RUN edge of each operation.
- Start at a=7, b=9, and pulse start again on RUN cycle 2 with a=1, b=1:
  - Second pulse ignored; product=63; single done pulse.
- Start at a=6, b=6; assert rst_n=0 asynchronously on RUN cycle 3 (between edges):
  - Outputs clear immediately; no done.
  - After release, a=2, b=11 yields product=22.
- start held high for 20 cycles with a=3, b=4:
  - done every 7 cycles (1 accept, 5 RUN, 1 DONE), product=12 each time.
